check: RTL and testbench

// - Checker stage downstream of the stimulus engine. Pairs each CHECK_FIFO entry
//   (expected vector, test-vector address, OR value) with the DUT response

---
 rtl/check.sv | 158 +++++++++++++++
 tb/tb_check.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/check.sv
// check: pairs CHECK_FIFO/RESULT_FIFO entries, compares them under a bitmask and logs failure records over Avalon-MM.
// Define CHECK_LOG_PASS_EN to add pass_count and log passing vectors as records with diff=0.
module check #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH = 2,
    parameter int STF_WIDTH = 24,
    parameter int ORV_WIDTH = 8,
    parameter int CHF_WIDTH = 52,
    parameter int SCC_WIDTH = 5,
    parameter int SCD_WIDTH = 24,
    parameter int CNT_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RES_BASE = 'h80000,
    parameter logic [ADDR_WIDTH-1:0] RES_LIMIT = 'hFFFFF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [CHF_WIDTH-1:0]  cfifo_data,
    output logic                  cfifo_rdreq,
    input  logic                  cfifo_rdempty,
    input  logic [STF_WIDTH-1:0]  rfifo_data,
    output logic                  rfifo_rdreq,
    input  logic                  rfifo_rdempty,
    input  logic [SCC_WIDTH-1:0]  sc_cmd,
    input  logic [SCD_WIDTH-1:0]  sc_data,
    output logic                  sc_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [BE_WIDTH-1:0]   mem_byteenable,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic                  mem_waitrequest,
    input  logic                  res_clear,
    output logic [CNT_WIDTH-1:0]  fail_count,
`ifdef CHECK_LOG_PASS_EN
    output logic [CNT_WIDTH-1:0]  pass_count,
`endif
    output logic                  overflow
);
    localparam logic [SCC_WIDTH-1:0] SCC_BITMASK = SCC_WIDTH'(1);
    typedef enum logic [1:0] {IDLE, COMPARE, WRITE} state_t;
    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, tv_q, tv_d;
    logic [STF_WIDTH-1:0] exp_q, exp_d, act_q, act_d, diff_q, diff_d, mask_q, mask_d, diff;
    logic [ORV_WIDTH-1:0] orv_q, orv_d;
    logic [CNT_WIDTH-1:0] fail_q, fail_d;
`ifdef CHECK_LOG_PASS_EN
    logic [CNT_WIDTH-1:0] pass_q, pass_d;
`endif
    logic [2:0] idx_q, idx_d;
    logic ovf_q, ovf_d, pop, room, log_rec;
    logic [DATA_WIDTH-1:0] word;
    // Requests are gated by reset_n so nothing is popped while the block is held in reset.
    assign pop = reset_n && state_q == IDLE && !cfifo_rdempty && !rfifo_rdempty;
    assign cfifo_rdreq = pop;
    assign rfifo_rdreq = pop;
    assign sc_ready = reset_n && state_q == IDLE && cfifo_rdempty;
    assign diff = (act_q ^ exp_q) & mask_q;
    assign room = ({1'b0, wr_ptr_q} + (ADDR_WIDTH+1)'(5)) <= {1'b0, RES_LIMIT};
`ifdef CHECK_LOG_PASS_EN
    assign log_rec = 1'b1;
    assign pass_count = pass_q;
`else
    assign log_rec = |diff;
`endif
    assign word = (idx_q == 3'd0) ? tv_q[15:0] :
                  (idx_q == 3'd1) ? {orv_q, 4'h0, tv_q[19:16]} :
                  (idx_q == 3'd2) ? act_q[15:0] :
                  (idx_q == 3'd3) ? {8'h00, act_q[23:16]} :
                  (idx_q == 3'd4) ? diff_q[15:0] : {8'h00, diff_q[23:16]};
    assign mem_write = state_q == WRITE;
    assign mem_address = wr_ptr_q;
    assign mem_writedata = (state_q == WRITE) ? word : '0;
    assign mem_byteenable = '1;
    assign fail_count = fail_q;
    assign overflow = ovf_q;
    always_comb begin
        state_d = state_q;
        wr_ptr_d = wr_ptr_q;
        idx_d = idx_q;
        exp_d = exp_q;
        tv_d = tv_q;
        orv_d = orv_q;
        act_d = act_q;
        diff_d = diff_q;
        mask_d = mask_q;
        fail_d = fail_q;
        ovf_d = ovf_q;
`ifdef CHECK_LOG_PASS_EN
        pass_d = pass_q;
`endif
        case (state_q)
            IDLE: begin
                if (sc_ready && sc_cmd == SCC_BITMASK) mask_d = sc_data[STF_WIDTH-1:0];
                if (res_clear) begin
                    fail_d = '0;
`ifdef CHECK_LOG_PASS_EN
                    pass_d = '0;
`endif
                    wr_ptr_d = RES_BASE;
                    ovf_d = 1'b0;
                end
                if (pop) begin
                    {exp_d, tv_d, orv_d} = cfifo_data;
                    act_d = rfifo_data;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                diff_d = diff;
                fail_d = (|diff && !(&fail_q)) ? fail_q + CNT_WIDTH'(1) : fail_q;
`ifdef CHECK_LOG_PASS_EN
                pass_d = (!(|diff) && !(&pass_q)) ? pass_q + CNT_WIDTH'(1) : pass_q;
`endif
                state_d = (log_rec && room) ? WRITE : IDLE;
                ovf_d = ovf_q | (log_rec && !room);
            end
            WRITE: if (!mem_waitrequest) begin
                wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
                idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
                state_d = (idx_q == 3'd5) ? IDLE : WRITE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wr_ptr_q <= RES_BASE;
            idx_q <= '0;
            exp_q <= '0;
            tv_q <= '0;
            orv_q <= '0;
            act_q <= '0;
            diff_q <= '0;
            mask_q <= '1;
            fail_q <= '0;
            ovf_q <= 1'b0;
`ifdef CHECK_LOG_PASS_EN
            pass_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            wr_ptr_q <= wr_ptr_d;
            idx_q <= idx_d;
            exp_q <= exp_d;
            tv_q <= tv_d;
            orv_q <= orv_d;
            act_q <= act_d;
            diff_q <= diff_d;
            mask_q <= mask_d;
            fail_q <= fail_d;
            ovf_q <= ovf_d;
`ifdef CHECK_LOG_PASS_EN
            pass_q <= pass_d;
`endif
        end
    end
endmodule

// File: tb/tb_check.sv
// tb_check: directed and random checks of the checker stage against a per-vector reference model.
module tb_check;
    localparam logic [19:0] BASE = 20'h80000;
    localparam logic [19:0] LIMIT = 20'h80008;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [51:0] cfifo_data = '0;
    logic cfifo_rdreq;
    logic cfifo_rdempty = 1'b1;
    logic [23:0] rfifo_data = '0;
    logic rfifo_rdreq;
    logic rfifo_rdempty = 1'b1;
    logic [4:0] sc_cmd = '0;
    logic [23:0] sc_data = '0;
    logic sc_ready;
    logic [19:0] mem_address;
    logic [1:0] mem_byteenable;
    logic mem_write;
    logic [15:0] mem_writedata;
    logic mem_waitrequest = 1'b0;
    logic res_clear = 1'b0;
    logic [15:0] fail_count;
`ifdef CHECK_LOG_PASS_EN
    logic [15:0] pass_count;
    logic [15:0] m_pass = '0;
`endif
    logic overflow;

    check #(.RES_LIMIT(LIMIT)) dut (
        .clock(clock), .reset_n(reset_n),
        .cfifo_data(cfifo_data), .cfifo_rdreq(cfifo_rdreq), .cfifo_rdempty(cfifo_rdempty),
        .rfifo_data(rfifo_data), .rfifo_rdreq(rfifo_rdreq), .rfifo_rdempty(rfifo_rdempty),
        .sc_cmd(sc_cmd), .sc_data(sc_data), .sc_ready(sc_ready),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest),
        .res_clear(res_clear), .fail_count(fail_count),
`ifdef CHECK_LOG_PASS_EN
        .pass_count(pass_count),
`endif
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail = 0;
    int n_push = 0;
    int cpops = 0;
    int rpops = 0;
    logic [51:0] cq[$];
    logic [23:0] rq[$];
    logic [35:0] ew[$];
    logic [35:0] gw[$];
    logic [23:0] m_mask = '1;
    logic [15:0] m_fail = '0;
    logic [19:0] m_ptr = BASE;
    logic m_ovf = 1'b0;
    logic rand_wait = 1'b0;
    logic ready_seen = 1'b0;
    int stall_left = 0;
    logic [19:0] stall_addr = '0;
    logic [15:0] stall_data = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_assert++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    // One clock: entered and left at a falling edge.
    task automatic cyc();
        logic c_rd, r_rd;
        cfifo_rdempty = (cq.size() == 0);
        rfifo_rdempty = (rq.size() == 0);
        cfifo_data = cfifo_rdempty ? '0 : cq[0];
        rfifo_data = rfifo_rdempty ? '0 : rq[0];
        mem_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        if (stall_left > 0 && mem_write && mem_address == stall_addr) begin
            mem_waitrequest = 1'b1;
            stall_left--;
            chk("stall_addr", 64'(mem_address), 64'(stall_addr));
            chk("stall_data", 64'(mem_writedata), 64'(stall_data));
        end
        #3;
        c_rd = cfifo_rdreq;
        r_rd = rfifo_rdreq;
        ready_seen = sc_ready;
        if (mem_write && !mem_waitrequest) gw.push_back({mem_address, mem_writedata});
        @(posedge clock);
        #1;
        if (c_rd) begin cpops++; if (cq.size() != 0) void'(cq.pop_front()); end
        if (r_rd) begin rpops++; if (rq.size() != 0) void'(rq.pop_front()); end
        @(negedge clock);
    endtask

    task automatic drain();
        int n = 0;
        do begin
            cyc();
            n++;
        end while (!(ready_seen && cq.size() == 0 && rq.size() == 0) && n < 1000);
        chk("drain_done", 64'(ready_seen && cq.size() == 0), 64'(1));
    endtask

    task automatic push(input logic [23:0] e, input logic [19:0] tv, input logic [7:0] ov, input logic [23:0] a);
        logic [23:0] d;
        logic rec;
        cq.push_back({e, tv, ov});
        rq.push_back(a);
        n_push++;
        d = (a ^ e) & m_mask;
        if (d != 0) m_fail = (m_fail == 16'hFFFF) ? m_fail : m_fail + 16'd1;
`ifdef CHECK_LOG_PASS_EN
        else m_pass = (m_pass == 16'hFFFF) ? m_pass : m_pass + 16'd1;
        rec = 1'b1;
`else
        rec = (d != 0);
`endif
        if (rec) begin
            if (int'(m_ptr) + 5 <= int'(LIMIT)) begin
                ew.push_back({m_ptr, tv[15:0]});
                ew.push_back({m_ptr + 20'd1, ov, 4'h0, tv[19:16]});
                ew.push_back({m_ptr + 20'd2, a[15:0]});
                ew.push_back({m_ptr + 20'd3, 8'h00, a[23:16]});
                ew.push_back({m_ptr + 20'd4, d[15:0]});
                ew.push_back({m_ptr + 20'd5, 8'h00, d[23:16]});
                m_ptr = m_ptr + 20'd6;
            end else m_ovf = 1'b1;
        end
    endtask

    task automatic cmp_writes(input string tag);
        chk({tag, "_nwr"}, 64'(gw.size()), 64'(ew.size()));
        for (int i = 0; i < gw.size() && i < ew.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), 64'(gw[i]), 64'(ew[i]));
        gw.delete();
        ew.delete();
    endtask

    task automatic verify(input string tag);
        drain();
        cmp_writes(tag);
        chk({tag, "_fail"}, 64'(fail_count), 64'(m_fail));
        chk({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
        chk({tag, "_cpop"}, 64'(cpops), 64'(n_push));
        chk({tag, "_rpop"}, 64'(rpops), 64'(n_push));
`ifdef CHECK_LOG_PASS_EN
        chk({tag, "_pass"}, 64'(pass_count), 64'(m_pass));
`endif
    endtask

    task automatic set_mask(input logic [23:0] m);
        drain();
        sc_cmd = 5'd1;
        sc_data = m;
        cyc();
        chk("mask_ready", 64'(ready_seen), 64'(1));
        sc_cmd = 5'd0;
        m_mask = m;
    endtask

    task automatic clear();
        drain();
        res_clear = 1'b1;
        cyc();
        res_clear = 1'b0;
        m_fail = '0;
`ifdef CHECK_LOG_PASS_EN
        m_pass = '0;
`endif
        m_ptr = BASE;
        m_ovf = 1'b0;
        chk("clr_fail", 64'(fail_count), 64'(0));
        chk("clr_ovf", 64'(overflow), 64'(0));
        chk("clr_addr", 64'(mem_address), 64'(BASE));
    endtask

    initial begin
        logic [23:0] e, a;
        int n;
        cfifo_rdempty = 1'b0;
        rfifo_rdempty = 1'b0;
        @(negedge clock);
        chk("rst_crdreq", 64'(cfifo_rdreq), 64'(0));
        chk("rst_rrdreq", 64'(rfifo_rdreq), 64'(0));
        chk("rst_ready", 64'(sc_ready), 64'(0));
        chk("rst_write", 64'(mem_write), 64'(0));
        chk("rst_wdata", 64'(mem_writedata), 64'(0));
        chk("rst_fail", 64'(fail_count), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        chk("rst_be", 64'(mem_byteenable), 64'(3));
        chk("rst_addr", 64'(mem_address), 64'(BASE));
        reset_n = 1'b1;
        cyc();
        chk("idle_ready", 64'(ready_seen), 64'(1));

        set_mask(24'h00FFFF);
        push(24'h123456, 20'h00001, 8'h00, 24'hFF3456);
        verify("bitmask");

        set_mask(24'hFFFFFF);
        push(24'hA5A5A5, 20'h00002, 8'h11, 24'hA5A5A5);
        verify("match");

        stall_addr = BASE + 20'd2;
        stall_data = 16'h0101;
        stall_left = 3;
        push(24'h000000, 20'h12345, 8'h3C, 24'h000101);
        verify("mismatch");
        chk("stall_used", 64'(stall_left), 64'(0));

        clear();
        push(24'h000000, 20'h00010, 8'h01, 24'h000003);
        push(24'h000000, 20'h00020, 8'h02, 24'h000030);
        verify("overflow");
        chk("ovf_set", 64'(overflow), 64'(1));
        chk("ovf_fail2", 64'(fail_count), 64'(2));

        clear();
        push(24'h0F0F0F, 20'hABCDE, 8'h77, 24'h0F0F00);
        cyc();
        cyc();
        res_clear = 1'b1;
        cyc();
        res_clear = 1'b0;
        verify("clr_ignored");

        clear();
        push(24'h000000, 20'h00033, 8'h44, 24'h000001);
        sc_cmd = 5'd1;
        sc_data = 24'hFFFF00;
        cyc();
        chk("ord_ready0", 64'(ready_seen), 64'(0));
        n = 0;
        while (!ready_seen && n < 100) begin
            cyc();
            n++;
        end
        chk("ord_ready1", 64'(ready_seen), 64'(1));
        sc_cmd = 5'd0;
        m_mask = 24'hFFFF00;
        push(24'h000000, 20'h00034, 8'h45, 24'h000001);
        verify("order");

        rand_wait = 1'b1;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1) clear();
            if ($urandom_range(0, 3) == 0) set_mask(24'($urandom));
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                e = 24'($urandom);
                a = ($urandom_range(0, 1) == 1) ? e : e ^ 24'($urandom);
                push(e, 20'($urandom), 8'($urandom), a);
            end
            verify($sformatf("rnd%0d", it));
        end

        rand_wait = 1'b0;
        set_mask(24'hFFFFFF);
        clear();
        push(24'h111111, 20'h54321, 8'h99, 24'h222222);
        cyc();
        cyc();
        cyc();
        cyc();
        chk("mid_write", 64'(mem_write), 64'(1));
        chk("mid_addr", 64'(mem_address), 64'(BASE + 20'd2));
        reset_n = 1'b0;
        #1;
        chk("arst_write", 64'(mem_write), 64'(0));
        chk("arst_wdata", 64'(mem_writedata), 64'(0));
        chk("arst_fail", 64'(fail_count), 64'(0));
        chk("arst_addr", 64'(mem_address), 64'(BASE));
        while (ew.size() > 2) void'(ew.pop_back());
        cmp_writes("partial");
        @(negedge clock);
        reset_n = 1'b1;
        m_mask = '1;
        m_fail = '0;
`ifdef CHECK_LOG_PASS_EN
        m_pass = '0;
`endif
        m_ptr = BASE;
        m_ovf = 1'b0;
        push(24'h000000, 20'h00777, 8'h5A, 24'h800000);
        verify("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
